// File: rtl/voxel_seq_pkg.sv
// Shared types and reset constants for the voxel frame sequencer.
// Camera components are signed fixed-point with 8 fractional bits.
package voxel_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WORLD_KICK = 3'd1,
    ST_WORLD_WAIT = 3'd2,
    ST_READY      = 3'd3,
    ST_FRAME_KICK = 3'd4,
    ST_FRAME_WAIT = 3'd5,
    ST_GAP        = 3'd6
  } seq_state_t;

  // Reset constants are 16-bit and sign-extended/truncated to CAM_W where used.
  localparam int CAM_RST_W = 16;
  localparam logic [2:0][CAM_RST_W-1:0] CAM_POS_RST   = {16'd2560, 16'd2560, 16'd2560};
  localparam logic [2:0][CAM_RST_W-1:0] CAM_DIR_RST   = {16'd0, 16'd0, 16'd256};
  localparam logic [1:0][CAM_RST_W-1:0] CAM_PLANE_RST = {16'd170, 16'd0};

  function automatic int eff_gap(input int g);
    return (g < 1) ? 1 : g;
  endfunction

endpackage

// File: rtl/voxel_frame_sequencer_if.sv
// Handshake and camera bus between the sequencer and the world/raycaster engines.
interface voxel_frame_sequencer_if #(parameter int CAM_W = 16);
  logic                  world_start;
  logic                  world_done;
  logic                  core_start;
  logic                  core_busy;
  logic                  core_done;
  logic [2:0][CAM_W-1:0] cam_pos;
  logic [2:0][CAM_W-1:0] cam_dir;
  logic [1:0][CAM_W-1:0] cam_plane;

  modport master (
    output world_start, core_start, cam_pos, cam_dir, cam_plane,
    input  world_done, core_busy, core_done
  );

  modport slave (
    input  world_start, core_start, cam_pos, cam_dir, cam_plane,
    output world_done, core_busy, core_done
  );
endinterface

// File: rtl/voxel_cam_shadow.sv
// Double-buffered camera: host commits land in the shadow, the active set
// only moves on a frame load, and only when a commit is pending.
module voxel_cam_shadow
  import voxel_seq_pkg::*;
#(
  parameter int CAM_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_commit,
  input  logic                  i_load,
  input  logic [2:0][CAM_W-1:0] i_pos,
  input  logic [2:0][CAM_W-1:0] i_dir,
  input  logic [1:0][CAM_W-1:0] i_plane,
  output logic [2:0][CAM_W-1:0] o_pos,
  output logic [2:0][CAM_W-1:0] o_dir,
  output logic [1:0][CAM_W-1:0] o_plane
);

  function automatic logic [2:0][CAM_W-1:0] ext3(input logic [2:0][CAM_RST_W-1:0] v);
    logic [2:0][CAM_W-1:0] r;
    for (int i = 0; i < 3; i++) r[i] = CAM_W'($signed(v[i]));
    return r;
  endfunction

  function automatic logic [1:0][CAM_W-1:0] ext2(input logic [1:0][CAM_RST_W-1:0] v);
    logic [1:0][CAM_W-1:0] r;
    for (int i = 0; i < 2; i++) r[i] = CAM_W'($signed(v[i]));
    return r;
  endfunction

  localparam logic [2:0][CAM_W-1:0] POS_RST   = ext3(CAM_POS_RST);
  localparam logic [2:0][CAM_W-1:0] DIR_RST   = ext3(CAM_DIR_RST);
  localparam logic [1:0][CAM_W-1:0] PLANE_RST = ext2(CAM_PLANE_RST);

  logic [2:0][CAM_W-1:0] r_sh_pos, r_sh_dir, r_act_pos, r_act_dir;
  logic [1:0][CAM_W-1:0] r_sh_plane, r_act_plane;
  logic                  r_pend;

  // On a same-cycle commit+load the active set takes the old shadow and the
  // fresh commit stays pending for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_pos    <= POS_RST;
      r_sh_dir    <= DIR_RST;
      r_sh_plane  <= PLANE_RST;
      r_act_pos   <= POS_RST;
      r_act_dir   <= DIR_RST;
      r_act_plane <= PLANE_RST;
      r_pend      <= 1'b0;
    end else begin
      if (i_load && r_pend) begin
        r_act_pos   <= r_sh_pos;
        r_act_dir   <= r_sh_dir;
        r_act_plane <= r_sh_plane;
      end
      if (i_commit) begin
        r_sh_pos   <= i_pos;
        r_sh_dir   <= i_dir;
        r_sh_plane <= i_plane;
        r_pend     <= 1'b1;
      end else if (i_load) begin
        r_pend     <= 1'b0;
      end
    end
  end

  assign o_pos   = r_act_pos;
  assign o_dir   = r_act_dir;
  assign o_plane = r_act_plane;

endmodule

// File: rtl/voxel_frame_sequencer.sv
// Sequences world builds and raycaster frames: pending requests, frame gap,
// frame counter and per-frame watchdog.
module voxel_frame_sequencer
  import voxel_seq_pkg::*;
#(
  parameter int CAM_W          = 16,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FCNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic                  i_regen,
  input  logic [2:0][CAM_W-1:0] i_host_cam_pos,
  input  logic [2:0][CAM_W-1:0] i_host_cam_dir,
  input  logic [1:0][CAM_W-1:0] i_host_cam_plane,
  input  logic                  i_host_cam_commit,
  input  logic                  i_err_clear,
  voxel_frame_sequencer_if.master bus,
  output logic                  o_world_ready,
  output logic [FCNT_W-1:0]     o_frame_count,
  output logic                  o_timeout_err,
  output logic [2:0]            o_seq_state
);

  localparam int GAP_EFF = eff_gap(GAP_CYCLES);
  localparam int GW      = (GAP_EFF < 2) ? 1 : $clog2(GAP_EFF);
  localparam int TW      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  seq_state_t        r_state, w_nxt;
  logic              r_live;
  logic              r_step_pend, r_regen_pend;
  logic [GW-1:0]     r_gap;
  logic [TW-1:0]     r_wdog;
  logic              r_world_ready, r_timeout_err;
  logic [FCNT_W-1:0] r_frame_count;
  logic              w_world_start, w_core_start, w_frame_done, w_timeout, w_regen_take;

  // r_live holds WORLD_KICK for one clock after reset so the start pulse
  // never appears while rst_n is low.
  always_comb begin
    w_nxt         = r_state;
    w_world_start = 1'b0;
    w_core_start  = 1'b0;
    w_frame_done  = 1'b0;
    w_timeout     = 1'b0;
    w_regen_take  = 1'b0;
    case (r_state)
      ST_IDLE:       w_nxt = ST_READY;
      ST_WORLD_KICK: if (r_live) begin
                       w_world_start = 1'b1;
                       w_nxt         = ST_WORLD_WAIT;
                     end
      ST_WORLD_WAIT: if (bus.world_done) w_nxt = ST_READY;
      ST_READY:      if (r_regen_pend) begin
                       w_regen_take = 1'b1;
                       w_nxt        = ST_WORLD_KICK;
                     end else if ((i_run || r_step_pend) && !bus.core_busy) begin
                       w_nxt = ST_FRAME_KICK;
                     end
      ST_FRAME_KICK: begin
                       w_core_start = 1'b1;
                       w_nxt        = ST_FRAME_WAIT;
                     end
      ST_FRAME_WAIT: if (bus.core_done) begin
                       w_frame_done = 1'b1;
                       w_nxt        = ST_GAP;
                     end else if (r_wdog == TW'(TIMEOUT_CYCLES - 1)) begin
                       w_timeout = 1'b1;
                       w_nxt     = ST_GAP;
                     end
      ST_GAP:        if (r_gap == GW'(GAP_EFF - 1)) w_nxt = ST_READY;
      default:       w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WORLD_KICK;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_live  <= 1'b1;
    end
  end

  // New requests win over same-cycle consumption so none are lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_pend  <= 1'b0;
      r_regen_pend <= 1'b0;
    end else begin
      if (i_step)            r_step_pend  <= 1'b1;
      else if (w_core_start) r_step_pend  <= 1'b0;
      if (i_regen)           r_regen_pend <= 1'b1;
      else if (w_regen_take) r_regen_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap         <= '0;
      r_wdog        <= '0;
      r_world_ready <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_gap  <= (r_state == ST_GAP) ? r_gap + GW'(1) : '0;
      if (w_core_start)                  r_wdog <= '0;
      else if (r_state == ST_FRAME_WAIT) r_wdog <= r_wdog + TW'(1);
      if (w_world_start)                                 r_world_ready <= 1'b0;
      else if (r_state == ST_WORLD_WAIT && bus.world_done) r_world_ready <= 1'b1;
      if (w_timeout)        r_timeout_err <= 1'b1;
      else if (i_err_clear) r_timeout_err <= 1'b0;
      if (w_frame_done) r_frame_count <= r_frame_count + FCNT_W'(1);
    end
  end

  voxel_cam_shadow #(.CAM_W(CAM_W)) u_cam (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_commit (i_host_cam_commit),
    .i_load   (w_core_start),
    .i_pos    (i_host_cam_pos),
    .i_dir    (i_host_cam_dir),
    .i_plane  (i_host_cam_plane),
    .o_pos    (bus.cam_pos),
    .o_dir    (bus.cam_dir),
    .o_plane  (bus.cam_plane)
  );

  assign bus.world_start   = w_world_start;
  assign bus.core_start    = w_core_start;
  assign o_world_ready     = r_world_ready;
  assign o_frame_count     = r_frame_count;
  assign o_timeout_err     = r_timeout_err;
  assign o_seq_state       = r_state;

endmodule

// File: tb/tb_voxel_frame_sequencer.sv
// Directed bench for voxel_frame_sequencer with a small auto-responding core model.
module tb_voxel_frame_sequencer;
  localparam int CAM_W = 16;
  localparam int LAT   = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n, run, step, regen, commit, err_clear, world_done;
  logic [2:0][CAM_W-1:0] host_pos, host_dir;
  logic [1:0][CAM_W-1:0] host_plane;
  logic                  world_ready, timeout_err;
  logic [31:0]           frame_count;
  logic [2:0]            seq_state;

  voxel_frame_sequencer_if #(.CAM_W(CAM_W)) bus ();

  voxel_frame_sequencer #(
    .CAM_W(CAM_W), .GAP_CYCLES(16), .TIMEOUT_CYCLES(64), .FCNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_run(run), .i_step(step), .i_regen(regen),
    .i_host_cam_pos(host_pos), .i_host_cam_dir(host_dir), .i_host_cam_plane(host_plane),
    .i_host_cam_commit(commit), .i_err_clear(err_clear), .bus(bus),
    .o_world_ready(world_ready), .o_frame_count(frame_count),
    .o_timeout_err(timeout_err), .o_seq_state(seq_state)
  );

  // Core model: busy for LAT cycles after core_start, then a done pulse.
  logic core_auto, m_busy, m_done;
  int   m_cnt;
  always @(posedge clk) begin
    if (!core_auto) begin
      m_cnt <= 0; m_busy <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (bus.core_start) begin
        m_cnt <= LAT; m_busy <= 1'b1;
      end else if (m_cnt == 1) begin
        m_cnt <= 0; m_done <= 1'b1; m_busy <= 1'b0;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end
  assign bus.core_done  = m_done;
  assign bus.core_busy  = m_busy;
  assign bus.world_done = world_done;

  int cyc = 0, n_start = 0, n_done = 0, last_done = 0, both_hi = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.core_start) n_start <= n_start + 1;
    if (bus.core_done) begin n_done <= n_done + 1; last_done <= cyc; end
    if (bus.core_start && bus.world_start) both_hi <= both_hi + 1;
  end

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag, input int budget);
    int i = 0;
    while (!bus.core_start && i < budget) begin tick(1); i++; end
    chk(tag, 64'(bus.core_start), 64'd1);
  endtask

  task automatic wait_wstart(input string tag, input int budget);
    int i = 0;
    while (!bus.world_start && i < budget) begin tick(1); i++; end
    chk(tag, 64'(bus.world_start), 64'd1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int i = 0;
    while (seq_state != st && i < budget) begin tick(1); i++; end
    chk(tag, 64'(seq_state), 64'(st));
  endtask

  task automatic wait_ndone(input string tag, input int n, input int budget);
    int i = 0;
    while (n_done < n && i < budget) begin tick(1); i++; end
    chk(tag, 64'(n_done), 64'(n));
  endtask

  localparam logic [47:0] POS_R  = 48'h0A00_0A00_0A00;
  localparam logic [47:0] DIR_R  = 48'h0000_0000_0100;
  localparam logic [31:0] PLN_R  = 32'h00AA_0000;
  localparam logic [47:0] POS_A  = 48'h0A00_0A00_0F00;
  localparam logic [47:0] DIR_A  = 48'h0000_0100_0000;
  localparam logic [31:0] PLN_A  = 32'h0000_00AA;
  localparam logic [47:0] POS_B  = 48'h0A00_0A00_03E8;

  int k1, ns0, nd0;

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; regen = 1'b0; commit = 1'b0;
    err_clear = 1'b0; world_done = 1'b0; core_auto = 1'b0;
    host_pos = POS_R; host_dir = DIR_R; host_plane = PLN_R;
    tick(3);
    chk("rst_wstart", 64'(bus.world_start), 64'd0);
    chk("rst_cstart", 64'(bus.core_start), 64'd0);
    chk("rst_wready", 64'(world_ready), 64'd0);
    chk("rst_fcnt", 64'(frame_count), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);
    chk("rst_pos", 64'(bus.cam_pos), 64'(POS_R));
    chk("rst_dir", 64'(bus.cam_dir), 64'(DIR_R));
    chk("rst_plane", 64'(bus.cam_plane), 64'(PLN_R));
    chk("rst_state", 64'(seq_state), 64'd1);

    // Reset release: world_start on cycle 1, then world_done at cycle 50
    rst_n = 1'b1;
    tick(1);
    chk("wstart_c1", 64'(bus.world_start), 64'd1);
    tick(1);
    chk("wstart_1cyc", 64'(bus.world_start), 64'd0);
    chk("state_wwait", 64'(seq_state), 64'd2);
    run = 1'b1; core_auto = 1'b1;
    tick(48);
    world_done = 1'b1; tick(1); world_done = 1'b0;
    chk("wready_set", 64'(world_ready), 64'd1);
    chk("cstart_early", 64'(bus.core_start), 64'd0);
    tick(1);
    chk("cstart_plus2", 64'(bus.core_start), 64'd1);

    // Continuous run: done-to-start spacing and frame count
    wait_ndone("five_frames", 5, 600);
    chk("fcnt5", 64'(frame_count), 64'd5);
    wait_start("next_start", 40);
    chk("spacing18", 64'(cyc - last_done), 64'd18);
    run = 1'b0;
    wait_state("stop_ready", 3'd3, 100);
    ns0 = n_start;
    tick(30);
    chk("idle_no_start", 64'(n_start), 64'(ns0));
    chk("fcnt_run", 64'(frame_count), 64'(n_done));

    // Single step, plus a second step during FRAME_WAIT
    step = 1'b1; tick(1); step = 1'b0;
    wait_start("step_start", 5);
    tick(5);
    step = 1'b1; tick(1); step = 1'b0;
    wait_state("step_ready", 3'd3, 200);
    tick(100);
    chk("step_two_frames", 64'(n_start), 64'(ns0 + 2));
    chk("step_idle", 64'(seq_state), 64'd3);

    // Commit during FRAME_WAIT: held until next FRAME_KICK
    step = 1'b1; tick(1); step = 1'b0;
    wait_start("cam_start1", 5);
    tick(5);
    host_pos = POS_A; host_dir = DIR_A; host_plane = PLN_A;
    commit = 1'b1; tick(1); commit = 1'b0;
    chk("cam_hold_fw", 64'(bus.cam_pos), 64'(POS_R));
    wait_state("cam_ready1", 3'd3, 100);
    tick(3);
    chk("cam_hold_rdy", 64'(bus.cam_pos), 64'(POS_R));
    step = 1'b1; tick(1); step = 1'b0;
    wait_start("cam_start2", 5);
    chk("cam_hold_kick", 64'(bus.cam_pos), 64'(POS_R));
    tick(1);
    chk("cam_pos_load", 64'(bus.cam_pos), 64'(POS_A));
    chk("cam_dir_load", 64'(bus.cam_dir), 64'(DIR_A));
    chk("cam_plane_load", 64'(bus.cam_plane), 64'(PLN_A));

    // Commit in the FRAME_KICK cycle itself is deferred one frame
    wait_state("cam_ready2", 3'd3, 100);
    host_pos = POS_B;
    step = 1'b1; tick(1); step = 1'b0;
    wait_start("cam_start3", 5);
    commit = 1'b1; tick(1); commit = 1'b0;
    chk("cam_defer", 64'(bus.cam_pos), 64'(POS_A));
    wait_state("cam_ready3", 3'd3, 100);
    step = 1'b1; tick(1); step = 1'b0;
    wait_start("cam_start4", 5);
    tick(1);
    chk("cam_deferred_load", 64'(bus.cam_pos), 64'(POS_B));
    wait_state("cam_ready4", 3'd3, 100);

    // Watchdog: core_done withheld
    core_auto = 1'b0; run = 1'b1;
    tick(1);
    wait_start("to_start1", 10);
    k1 = cyc;
    tick(64);
    chk("to_not_yet", 64'(timeout_err), 64'd0);
    chk("to_fwait", 64'(seq_state), 64'd5);
    tick(1);
    chk("to_set", 64'(timeout_err), 64'd1);
    chk("to_gap", 64'(seq_state), 64'd6);
    chk("to_fcnt", 64'(frame_count), 64'(n_done));
    wait_start("to_start2", 40);
    chk("to_rekick", 64'(cyc - k1), 64'd82);
    tick(1);
    err_clear = 1'b1; tick(1); err_clear = 1'b0;
    chk("err_clear", 64'(timeout_err), 64'd0);
    tick(62);
    err_clear = 1'b1; tick(1); err_clear = 1'b0;
    chk("set_wins", 64'(timeout_err), 64'd1);
    run = 1'b0;
    wait_state("to_ready", 3'd3, 40);
    err_clear = 1'b1; tick(1); err_clear = 1'b0;
    chk("err_clear2", 64'(timeout_err), 64'd0);
    chk("to_fcnt2", 64'(frame_count), 64'(n_done));

    // Regen mid-frame
    core_auto = 1'b1;
    tick(1);
    nd0 = n_done;
    step = 1'b1; tick(1); step = 1'b0;
    wait_start("rg_start", 5);
    tick(5);
    regen = 1'b1; tick(1); regen = 1'b0;
    chk("rg_wready_hold", 64'(world_ready), 64'd1);
    wait_wstart("rg_wstart", 100);
    chk("rg_frame_done", 64'(n_done), 64'(nd0 + 1));
    chk("rg_fcnt", 64'(frame_count), 64'(n_done));
    tick(1);
    chk("rg_wready_drop", 64'(world_ready), 64'd0);
    chk("rg_wwait", 64'(seq_state), 64'd2);
    run = 1'b1;
    ns0 = n_start;
    tick(20);
    chk("rg_no_frames", 64'(n_start), 64'(ns0));
    world_done = 1'b1; tick(1); world_done = 1'b0;
    chk("rg_wready_set", 64'(world_ready), 64'd1);
    wait_start("rg_resume", 5);

    // Async reset mid-frame
    tick(10);
    rst_n = 1'b0; run = 1'b0; core_auto = 1'b0;
    #1;
    chk("mr_fcnt", 64'(frame_count), 64'd0);
    chk("mr_wready", 64'(world_ready), 64'd0);
    chk("mr_pos", 64'(bus.cam_pos), 64'(POS_R));
    chk("mr_dir", 64'(bus.cam_dir), 64'(DIR_R));
    chk("mr_state", 64'(seq_state), 64'd1);
    chk("mr_starts", 64'({bus.world_start, bus.core_start}), 64'd0);
    chk("never_both", 64'(both_hi), 64'd0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
